// File: rtl/rapid_pkg.sv
// Shared RV32I decode types: opcode encodings, decode-stage FSM states,
// register count and the immediate extraction helper.
package rapid_pkg;

  localparam int REG_COUNT = 32;

  typedef enum logic [6:0] {
    LUI      = 7'b0110111,
    AUIPC    = 7'b0010111,
    JAL      = 7'b1101111,
    JALR     = 7'b1100111,
    BRANCH   = 7'b1100011,
    LOAD     = 7'b0000011,
    STORE    = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP       = 7'b0110011,
    MISC_MEM = 7'b0001111,
    SYSTEM   = 7'b1110011
  } opcode_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ID_state_t;

  // 32-bit immediate for the instruction's format; R-type and anything
  // without an immediate (including SYSTEM) yields zero.
  function automatic logic [31:0] imm32(input logic [31:0] insn);
    logic [31:0] imm;
    imm = '0;
    case (insn[6:0])
      LOAD, OP_IMM, JALR: imm = {{20{insn[31]}}, insn[31:20]};
      STORE:              imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      BRANCH:             imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25],
                                 insn[11:8], 1'b0};
      LUI, AUIPC:         imm = {insn[31:12], 12'b0};
      JAL:                imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20],
                                 insn[30:21], 1'b0};
      default:            imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// Decode-stage bus: fetch handshake, writeback port and execute-side bundle.
// Handshake: fetch pulses i_valid and a transfer happens on any edge where
// i_valid & o_ready; execute takes the bundle on any edge where o_valid &
// i_ex_ready; i_flush discards the held bundle and any same-cycle transfer.
interface instruction_decode_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic [XLEN-1:0] i_pc;
  logic [31:0]     i_instruction;
  logic            o_ready;
  logic            i_flush;
  logic            i_wb_en;
  logic [4:0]      i_wb_rd;
  logic [XLEN-1:0] i_wb_data;
  logic            i_ex_ready;
  logic            o_valid;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_imm;
  logic [XLEN-1:0] o_rs1_data;
  logic [XLEN-1:0] o_rs2_data;
  logic [6:0]      o_opcode;
  logic [2:0]      o_funct3;
  logic [6:0]      o_funct7;
  logic [4:0]      o_rd;
  logic [4:0]      o_rs1;
  logic [4:0]      o_rs2;
  logic            o_illegal;

  modport slave (
    input  i_valid, i_pc, i_instruction, i_flush,
    input  i_wb_en, i_wb_rd, i_wb_data, i_ex_ready,
    output o_ready, o_valid, o_pc, o_imm, o_rs1_data, o_rs2_data,
    output o_opcode, o_funct3, o_funct7, o_rd, o_rs1, o_rs2, o_illegal
  );

  modport master (
    output i_valid, i_pc, i_instruction, i_flush,
    output i_wb_en, i_wb_rd, i_wb_data, i_ex_ready,
    input  o_ready, o_valid, o_pc, o_imm, o_rs1_data, o_rs2_data,
    input  o_opcode, o_funct3, o_funct7, o_rd, o_rs1, o_rs2, o_illegal
  );

endinterface

// File: rtl/register_file.sv
// 32 x XLEN integer register file: two asynchronous read ports, one
// synchronous write port, x0 hard-wired to zero, write-through on reads.
module register_file
  import rapid_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs [REG_COUNT];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Same-cycle write is forwarded so a reader never sees the stale value.
  always_comb begin
    rdata_a = regs[raddr_a];
    if (raddr_a == 5'd0)                rdata_a = '0;
    else if (we && (waddr == raddr_a))  rdata_a = wdata;
  end

  always_comb begin
    rdata_b = regs[raddr_b];
    if (raddr_b == 5'd0)                rdata_b = '0;
    else if (we && (waddr == raddr_b))  rdata_b = wdata;
  end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: one-entry EMPTY/FULL skid holding the decoded bundle.
// Optional illegal-instruction flagging is built with RAPID_ILLEGAL_INSN_EN.
module instruction_decode
  import rapid_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  instruction_decode_if.slave  bus,
  output ID_state_t            o_state
);

  ID_state_t       state_q;
  ID_state_t       state_d;
  logic            accept;
  logic            load;
  logic [31:0]     insn;
  logic [XLEN-1:0] rs1_rdata;
  logic [XLEN-1:0] rs2_rdata;
  logic signed [31:0] imm_s;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [6:0]      opcode_q;
  logic [2:0]      funct3_q;
  logic [6:0]      funct7_q;
  logic [4:0]      rd_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;

  assign insn   = bus.i_instruction;
  assign imm_s  = imm32(insn);

  assign bus.o_ready = (state_q == EMPTY) || ((state_q == FULL) && bus.i_ex_ready);
  assign accept      = bus.i_valid && bus.o_ready;
  // A flush in the accept cycle throws the incoming instruction away too.
  assign load        = accept && !bus.i_flush;

  register_file #(.XLEN(XLEN)) u_regfile (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .we      (bus.i_wb_en),
    .waddr   (bus.i_wb_rd),
    .wdata   (bus.i_wb_data),
    .raddr_a (insn[19:15]),
    .rdata_a (rs1_rdata),
    .raddr_b (insn[24:20]),
    .rdata_b (rs2_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (bus.i_ex_ready) state_d = accept ? FULL : EMPTY;
    endcase
    if (bus.i_flush) state_d = EMPTY;
  end

  // Operands are captured once at accept and never refreshed while held.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else if (load) begin
      pc_q       <= bus.i_pc;
      imm_q      <= XLEN'(imm_s);
      rs1_data_q <= rs1_rdata;
      rs2_data_q <= rs2_rdata;
      opcode_q   <= insn[6:0];
      funct3_q   <= insn[14:12];
      funct7_q   <= insn[31:25];
      rd_q       <= insn[11:7];
      rs1_q      <= insn[19:15];
      rs2_q      <= insn[24:20];
    end
  end

`ifdef RAPID_ILLEGAL_INSN_EN
  logic illegal_d;
  logic illegal_q;

  always_comb begin
    illegal_d = 1'b1;
    case (insn[6:0])
      LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, MISC_MEM, SYSTEM:
        illegal_d = 1'b0;
      OP_IMM: begin
        if (insn[14:12] == 3'b001)      illegal_d = (insn[31:25] != 7'b0000000);
        else if (insn[14:12] == 3'b101) illegal_d = !((insn[31:25] == 7'b0000000) ||
                                                      (insn[31:25] == 7'b0100000));
        else                            illegal_d = 1'b0;
      end
      // Only ADD/SUB and SRL/SRA have a 0100000 alternate encoding.
      OP: illegal_d = !((insn[31:25] == 7'b0000000) ||
                        ((insn[31:25] == 7'b0100000) &&
                         ((insn[14:12] == 3'b000) || (insn[14:12] == 3'b101))));
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)   illegal_q <= 1'b0;
    else if (load) illegal_q <= illegal_d;
  end

  assign bus.o_illegal = illegal_q;
`else
  assign bus.o_illegal = 1'b0;
`endif

  assign bus.o_valid    = (state_q == FULL);
  assign bus.o_pc       = pc_q;
  assign bus.o_imm      = imm_q;
  assign bus.o_rs1_data = rs1_data_q;
  assign bus.o_rs2_data = rs2_data_q;
  assign bus.o_opcode   = opcode_q;
  assign bus.o_funct3   = funct3_q;
  assign bus.o_funct7   = funct7_q;
  assign bus.o_rd       = rd_q;
  assign bus.o_rs1      = rs1_q;
  assign bus.o_rs2      = rs2_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed steps plus a short random phase,
// with a bundle scoreboard fed from an independent decode/register model.
module tb_instruction_decode;
  import rapid_pkg::*;

  localparam int XLEN = 32;
  localparam int W    = 4 * XLEN + 7 + 3 + 7 + 15 + 1;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  ID_state_t state;

  instruction_decode_if #(.XLEN(XLEN)) bus ();

  instruction_decode #(.XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus),
    .o_state (state)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  ref_rf[32];

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic [31:0] t;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: return $signed(i) >>> 20;
      7'h23: begin
        t = $signed(i) >>> 20;
        t[4:0] = i[11:7];
        return t;
      end
      7'h63: begin
        t = {i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0};
        return $signed(t) >>> 19;
      end
      7'h37, 7'h17: return {i[31:12], 12'h000};
      7'h6f: begin
        t = {i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0};
        return $signed(t) >>> 11;
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] i);
`ifdef RAPID_ILLEGAL_INSN_EN
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    case (i[6:0])
      7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0f, 7'h73: return 1'b0;
      7'h13: begin
        if (f3 == 3'd1) return f7 != 7'h00;
        if (f3 == 3'd5) return !(f7 == 7'h00 || f7 == 7'h20);
        return 1'b0;
      end
      7'h33: begin
        if (f7 == 7'h00) return 1'b0;
        if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return 1'b0;
        return 1'b1;
      end
      default: return 1'b1;
    endcase
`else
    return i[0] & 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (bus.i_wb_en && bus.i_wb_rd == a) return bus.i_wb_data;
    return ref_rf[a];
  endfunction

  function automatic logic [W-1:0] pack(
    input logic [31:0] pc, imm, r1, r2,
    input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
    input logic [4:0] rd, rs1, rs2, input logic ill);
    return {pc, imm, r1, r2, opc, f3, f7, rd, rs1, rs2, ill};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sampled at negedge: retire the head on an execute transfer, push on accept.
  task automatic sb_step();
    logic [31:0]  ins;
    logic [W-1:0] e;
    if (rst) begin
      exp_q.delete();
      for (int k = 0; k < 32; k++) ref_rf[k] = 32'h0;
      return;
    end
    if (bus.o_valid && bus.i_flush) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
    end else if (bus.o_valid && bus.i_ex_ready) begin
      if (exp_q.size() == 0) check("sb_underflow", 0, 1);
      else begin
        e = exp_q.pop_front();
        check("sb_bundle",
              pack(bus.o_pc, bus.o_imm, bus.o_rs1_data, bus.o_rs2_data, bus.o_opcode,
                   bus.o_funct3, bus.o_funct7, bus.o_rd, bus.o_rs1, bus.o_rs2, bus.o_illegal),
              e);
      end
    end
    if (bus.i_valid && bus.o_ready && !bus.i_flush) begin
      ins = bus.i_instruction;
      exp_q.push_back(pack(bus.i_pc, ref_imm(ins), ref_read(ins[19:15]), ref_read(ins[24:20]),
                           ins[6:0], ins[14:12], ins[31:25], ins[11:7], ins[19:15],
                           ins[24:20], ref_illegal(ins)));
    end
    if (bus.i_wb_en && bus.i_wb_rd != 5'd0) ref_rf[bus.i_wb_rd] = bus.i_wb_data;
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge clk);
    sb_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_valid   = 1'b0;
    bus.i_flush   = 1'b0;
    bus.i_wb_en   = 1'b0;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] insn);
    int n;
    n = 0;
    bus.i_valid       = 1'b1;
    bus.i_pc          = pc;
    bus.i_instruction = insn;
    #1;
    while (!bus.o_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.o_ready) check("ready_timeout", 0, 1);
    tick();
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    bus.i_wb_en   = 1'b1;
    bus.i_wb_rd   = rd;
    bus.i_wb_data = data;
    tick();
    bus.i_wb_en   = 1'b0;
  endtask

  logic [31:0] dir_insn [7] = '{32'hFE612E23, 32'hABCDE0B7, 32'hFFDFF06F, 32'hFE000EE3,
                                32'hFFC28067, 32'h00001863, 32'h00208033};
  logic [31:0] dir_imm  [7] = '{32'hFFFFFFFC, 32'hABCDE000, 32'hFFFFFFFC, 32'hFFFFFFFC,
                                32'hFFFFFFFC, 32'h00000010, 32'h00000000};
  logic [31:0] extra    [8] = '{32'h4050D093, 32'h40009093, 32'h02208033, 32'h40208033,
                                32'h00000073, 32'h0FF0000F, 32'h0000007B, 32'h12345297};
  logic [6:0]  rnd_ops  [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  initial begin
    logic [31:0] r;
    logic        exp_ill;
    bus.i_valid = 0; bus.i_pc = 0; bus.i_instruction = 0; bus.i_flush = 0;
    bus.i_wb_en = 0; bus.i_wb_rd = 0; bus.i_wb_data = 0; bus.i_ex_ready = 1;

    // Reset
    repeat (3) tick();
    rst = 1'b0;
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_o_ready", bus.o_ready, 1);
    check("rst_o_pc", bus.o_pc, 0);
    check("rst_o_imm", bus.o_imm, 0);
    check("rst_o_rs1_data", bus.o_rs1_data, 0);
    check("rst_o_rd", bus.o_rd, 0);
    check("rst_o_illegal", bus.o_illegal, 0);
    check("rst_state", state, EMPTY);

    wb(5'd2, 32'h00000022);
    wb(5'd6, 32'h00000066);

    // ADDI x1,x0,-5 at 0x100
    send(32'h100, 32'hFFB00093);
    idle();
    check("addi_valid", bus.o_valid, 1);
    check("addi_rd", bus.o_rd, 1);
    check("addi_imm", bus.o_imm, 32'hFFFFFFFB);
    check("addi_pc", bus.o_pc, 32'h100);
    check("addi_rs1_data", bus.o_rs1_data, 0);
    tick();
    check("addi_drop", bus.o_valid, 0);

    // Hold: ADD x7,x2,x6 stalled for 3 cycles, stray valid and x2 write ignored
    bus.i_ex_ready = 1'b0;
    send(32'h104, 32'h006103B3);
    for (int k = 0; k < 3; k++) begin
      bus.i_valid = 1'b1; bus.i_pc = 32'h500; bus.i_instruction = 32'h00500093;
      bus.i_wb_en = 1'b1; bus.i_wb_rd = 5'd2; bus.i_wb_data = 32'h999;
      check("hold_valid", bus.o_valid, 1);
      check("hold_ready", bus.o_ready, 0);
      check("hold_pc", bus.o_pc, 32'h104);
      check("hold_rs1_data", bus.o_rs1_data, 32'h22);
      check("hold_rs2_data", bus.o_rs2_data, 32'h66);
      tick();
    end
    idle();
    bus.i_ex_ready = 1'b1;
    #1;
    check("hold_release_ready", bus.o_ready, 1);
    tick();
    check("hold_release_valid", bus.o_valid, 0);
    check("hold_release_state", state, EMPTY);

    // Bypass: ADD x3,x5,x0 with x5 written in the accept cycle
    bus.i_wb_en = 1'b1; bus.i_wb_rd = 5'd5; bus.i_wb_data = 32'hDEADBEEF;
    send(32'h108, 32'h000281B3);
    idle();
    check("byp_rs1_data", bus.o_rs1_data, 32'hDEADBEEF);
    check("byp_rs2_data", bus.o_rs2_data, 0);
    check("byp_rs1", bus.o_rs1, 5);
    check("byp_rd", bus.o_rd, 3);
    tick();

    // x0 is never written nor bypassed
    wb(5'd0, 32'h1234);
    bus.i_wb_en = 1'b1; bus.i_wb_rd = 5'd0; bus.i_wb_data = 32'h1234;
    send(32'h10C, 32'h000001B3);
    idle();
    check("x0_rs1_data", bus.o_rs1_data, 0);
    tick();

    // All-ones word
`ifdef RAPID_ILLEGAL_INSN_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    send(32'h200, 32'hFFFFFFFF);
    idle();
    check("ones_valid", bus.o_valid, 1);
    check("ones_illegal", bus.o_illegal, exp_ill);
    tick();

    // Back-to-back formats, no bubble
    for (int k = 0; k < 7; k++) begin
      send(32'h1000 + 32'(k * 4), dir_insn[k]);
      check("b2b_valid", bus.o_valid, 1);
      check("b2b_imm", bus.o_imm, dir_imm[k]);
    end
    for (int k = 0; k < 8; k++) send(32'h2000 + 32'(k * 4), extra[k]);
    idle();
    tick();

    // Flush with a same-cycle valid while FULL
    bus.i_ex_ready = 1'b0;
    send(32'h300, 32'hFFB00093);
    bus.i_flush = 1'b1;
    bus.i_valid = 1'b1; bus.i_pc = 32'h304; bus.i_instruction = 32'h00100113;
    tick();
    idle();
    check("flush_valid", bus.o_valid, 0);
    check("flush_state", state, EMPTY);
    check("flush_ready", bus.o_ready, 1);
    bus.i_ex_ready = 1'b1;

    // Random traffic
    for (int k = 0; k < 60; k++) begin
      r = $urandom();
      bus.i_ex_ready    = 1'($urandom_range(0, 1));
      bus.i_valid       = 1'($urandom_range(0, 1));
      bus.i_pc          = {$urandom_range(0, 65535), 2'b00};
      bus.i_instruction = {r[31:7], rnd_ops[$urandom_range(0, 8)]};
      bus.i_flush       = ($urandom_range(0, 15) == 0);
      bus.i_wb_en       = 1'($urandom_range(0, 1));
      bus.i_wb_rd       = 5'($urandom_range(0, 31));
      bus.i_wb_data     = $urandom();
      tick();
    end
    idle();
    bus.i_ex_ready = 1'b1;
    repeat (3) tick();

    // Reset while holding an instruction
    bus.i_ex_ready = 1'b0;
    send(32'h400, 32'h000281B3);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", bus.o_valid, 0);
    check("midrst_ready", bus.o_ready, 1);
    check("midrst_state", state, EMPTY);
    bus.i_ex_ready = 1'b1;
    send(32'h404, 32'h000281B3);
    idle();
    check("midrst_rf_cleared", bus.o_rs1_data, 0);
    repeat (2) tick();

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and register width.
REQ-002 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_valid  input  1  one-cycle pulse from fetch stage: instruction and PC present.
REQ-005 SHALL have port i_pc  input  XLEN  PC of the fetched instruction.
REQ-006 SHALL have port i_instruction  input  32  raw RV32I instruction word.
REQ-007 SHALL have port o_ready  output  1  to fetch stage: decode can accept this cycle; combinational.
REQ-008 SHALL have port i_flush  input  1  branch redirect: discard the held instruction.
REQ-009 SHALL have port i_wb_en, i_wb_rd[4:0], i_wb_data[XLEN]  input  register file write port from writeback.
REQ-010 SHALL have port i_ex_ready  input  1  execute stage accepts the decoded bundle.
REQ-011 SHALL have port o_valid  output  1  decoded bundle valid.
REQ-012 SHALL have port o_pc, o_imm, o_rs1_data, o_rs2_data  output  XLEN each  PC, sign-extended immediate and operands.
REQ-013 SHALL have port o_opcode[6:0], o_funct3[2:0], o_funct7[6:0], o_rd[4:0], o_rs1[4:0], o_rs2[4:0]  output  decoded fields.
REQ-014 SHALL have port o_illegal  output  1  instruction not recognised (see Configuration).

Function
REQ-015 SHALL implement states EMPTY and FULL; reset enters EMPTY.
REQ-016 SHALL drive o_ready = (state==EMPTY) | (state==FULL & i_ex_ready).
REQ-017 SHALL accept on i_valid & o_ready; all outputs register on that edge; latency exactly one cycle from i_valid to o_valid.
REQ-018 SHALL transition: EMPTY->FULL on accept; FULL->EMPTY on i_ex_ready without accept; FULL->FULL on i_ex_ready with accept (back-to-back, no bubble); FULL holds all outputs stable while i_ex_ready=0.
REQ-019 SHALL ignore i_valid when o_ready=0; fetch guarantees it holds its instruction until ready.
REQ-020 SHALL on i_flush force EMPTY and o_valid=0 next cycle, discarding any same-cycle accept; flush has priority over all other events.
REQ-021 SHALL generate o_imm by opcode: I (load, OP-IMM, JALR), S, B, U, J formats, sign-extended to XLEN; R-type and unknown give 0.
REQ-022 SHALL read rs1/rs2 from a 32xXLEN register file; x0 reads 0; writes to x0 are ignored.
REQ-023 SHALL bypass i_wb_data to the operand when i_wb_en and i_wb_rd equals the rs index being read in the accept cycle (rd != 0).
REQ-024 SHALL not refresh operands while FULL; hazards from later writes are execute's responsibility.

Reset
REQ-025 SHALL on reset clear o_valid, o_illegal, o_pc, o_imm, operand data and all field outputs to 0, and state to EMPTY.
REQ-026 SHALL clear all 32 registers to 0 on reset.
REQ-027 SHALL on reset mid-operation drop any held instruction; o_ready is 1 in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, with RAPID_ILLEGAL_INSN_EN defined, set o_illegal=1 for opcodes outside RV32I base and for invalid funct3/funct7 combinations of OP/OP-IMM shifts; bundle still issues with o_valid=1.
REQ-029 SHALL, without RAPID_ILLEGAL_INSN_EN, tie o_illegal to 0 and omit the check logic.

Structure
REQ-030 SHALL place the opcode enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM), the ID_state_t enum and REG_COUNT=32 in rapid_pkg.
REQ-031 SHALL instantiate one sub-module register_file: two async read ports, one sync write port, write-through bypass.

Verification
REQ-032 SHALL verify ADDI x1,x0,-5 (0xFFB00093) at PC 0x100: one cycle later o_valid=1, o_rd=1, o_imm=0xFFFFFFFB, o_pc=0x100.
REQ-033 SHALL verify hold: i_ex_ready=0 for 3 cycles after accept -> outputs unchanged, o_ready=0; ready=1 -> o_valid drops next cycle.
REQ-034 SHALL verify bypass: i_wb_en=1, rd=5, data=0xDEADBEEF in the same cycle as accepting ADD x3,x5,x0 -> o_rs1_data=0xDEADBEEF.
REQ-035 SHALL verify flush: i_flush together with i_valid while FULL -> next cycle o_valid=0, state EMPTY.
REQ-036 SHALL verify decoding of 0xFFFFFFFF: o_illegal=1 with RAPID_ILLEGAL_INSN_EN, 0 without it; a write to x0 with data 0x1234 -> subsequent rs1=x0 reads 0.
